// File: rtl/alu_pkg.sv
// Shared definitions for the multicycle ALU: MIPS opcode/funct encodings
// and the control FSM state type.
package alu_pkg;

  // Primary opcodes
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  // Function field values for R-type instructions
  localparam logic [5:0] F_SLL   = 6'b000000;
  localparam logic [5:0] F_SRL   = 6'b000010;
  localparam logic [5:0] F_SRA   = 6'b000011;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_ADD   = 6'b100000;
  localparam logic [5:0] F_SUB   = 6'b100010;
  localparam logic [5:0] F_AND   = 6'b100100;
  localparam logic [5:0] F_OR    = 6'b100101;
  localparam logic [5:0] F_XOR   = 6'b100110;
  localparam logic [5:0] F_NOR   = 6'b100111;
  localparam logic [5:0] F_SLT   = 6'b101010;

  // Control FSM: idle/single-cycle execution, or iterating a multiply
  typedef enum logic {
    S_IDLE = 1'b0,
    S_MUL  = 1'b1
  } state_t;

endpackage

// File: rtl/multicycle_alu_if.sv
// Request/response bundle between the operand-read stage and the ALU.
// The master side (control/pipeline) drives the request, the slave side
// (the ALU) returns the registered results and status.
interface multicycle_alu_if #(
  parameter int WIDTH = 32
) ();

  localparam int SHW = $clog2(WIDTH);

  logic             start;
  logic [5:0]       opcode;
  logic [5:0]       funct;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] result_hi;
  logic             rw;
  logic             zero;
  logic             overflow;
  logic             illegal;

  modport master (
    output start, opcode, funct, shamt, in1, in2,
    input  busy, done, result, result_hi, rw, zero, overflow, illegal
  );

  modport slave (
    input  start, opcode, funct, shamt, in1, in2,
    output busy, done, result, result_hi, rw, zero, overflow, illegal
  );

endinterface

// File: rtl/seq_multiplier.sv
// Iterative unsigned shift-add multiplier. The accumulator holds
// {partial product, remaining multiplier bits}; each step conditionally adds
// the multiplicand into the upper half and shifts the whole thing right.
// o_product shows the accumulator as it will be after the current step, so
// the caller can capture the final product on the same edge as the last step.
module seq_multiplier #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_load,
  input  logic               i_step,
  input  logic [WIDTH-1:0]   i_mcand,
  input  logic [WIDTH-1:0]   i_mplier,
  output logic               o_last,
  output logic [2*WIDTH-1:0] o_product
);

  localparam int SHW = $clog2(WIDTH);
  localparam logic [SHW-1:0] LAST_STEP = SHW'(WIDTH - 1);

  logic [WIDTH-1:0]   r_mcand;
  logic [2*WIDTH-1:0] r_acc;
  logic [SHW-1:0]     r_count;
  logic [WIDTH:0]     w_addSum;
  logic [2*WIDTH-1:0] w_accNext;

  // One shift-add step: add the multiplicand when the current LSB is set,
  // keeping the carry as the new top bit after the shift
  always_comb begin
    w_addSum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_mcand} : '0);
    w_accNext = {w_addSum, r_acc[WIDTH-1:1]};
  end

  assign o_product = w_accNext;
  assign o_last    = (r_count == LAST_STEP);

  // Load latches operands and clears the partial product; step advances one bit
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mcand <= '0;
      r_acc   <= '0;
      r_count <= '0;
    end else if (i_load) begin
      r_mcand <= i_mcand;
      r_acc   <= {{WIDTH{1'b0}}, i_mplier};
      r_count <= '0;
    end else if (i_step) begin
      r_acc   <= w_accNext;
      r_count <= r_count + 1'b1;
    end
  end

endmodule

// File: rtl/multicycle_alu.sv
// Registered ALU with one-cycle arithmetic/logic/shift operations and an
// iterative MULTU. Single-cycle results appear one cycle after start; a
// multiply keeps busy high for WIDTH cycles and then reports the hi/lo pair.
module multicycle_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  multicycle_alu_if.slave      bus
);

  logic [WIDTH-1:0]   w_sum;
  logic [WIDTH-1:0]   w_diff;
  logic [WIDTH-1:0]   w_result;
  logic               w_rw;
  logic               w_zero;
  logic               w_overflow;
  logic               w_illegal;
  logic               w_isMul;
  logic               w_mulLoad;
  logic               w_mulStep;
  logic               w_mulLast;
  logic [2*WIDTH-1:0] w_product;

  state_t             r_state;
  logic               r_busy;
  logic               r_done;
  logic [WIDTH-1:0]   r_result;
  logic [WIDTH-1:0]   r_resultHi;
  logic               r_rw;
  logic               r_zero;
  logic               r_overflow;
  logic               r_illegal;

  assign w_sum  = bus.in1 + bus.in2;
  assign w_diff = bus.in1 - bus.in2;

  // Decode opcode/funct into the next single-cycle result and status bits
  always_comb begin
    w_result   = '0;
    w_rw       = 1'b0;
    w_overflow = 1'b0;
    w_illegal  = 1'b0;
    w_isMul    = 1'b0;
    w_zero     = 1'b0;
    case (bus.opcode)
      OP_RTYPE: begin
        w_rw = 1'b1;
        case (bus.funct)
          F_ADD: begin
            w_result   = w_sum;
            w_overflow = (bus.in1[WIDTH-1] == bus.in2[WIDTH-1]) && (w_sum[WIDTH-1] != bus.in1[WIDTH-1]);
          end
          F_SUB: begin
            w_result   = w_diff;
            w_overflow = (bus.in1[WIDTH-1] != bus.in2[WIDTH-1]) && (w_diff[WIDTH-1] != bus.in1[WIDTH-1]);
          end
          F_AND:   w_result = bus.in1 & bus.in2;
          F_OR:    w_result = bus.in1 | bus.in2;
          F_XOR:   w_result = bus.in1 ^ bus.in2;
          F_NOR:   w_result = ~(bus.in1 | bus.in2);
          F_SLT:   w_result = {{(WIDTH-1){1'b0}}, ($signed(bus.in1) < $signed(bus.in2))};
          F_SLL:   w_result = bus.in2 << bus.shamt;
          F_SRL:   w_result = bus.in2 >> bus.shamt;
          F_SRA:   w_result = $signed(bus.in2) >>> bus.shamt;
          F_MULTU: w_isMul  = 1'b1;
          default: begin
            w_rw      = 1'b0;
            w_illegal = 1'b1;
          end
        endcase
      end
      OP_LW: begin
        w_result = w_sum;
        w_rw     = 1'b1;
      end
      OP_SW:  w_result = w_sum;
      OP_BEQ: w_result = w_diff;
      default: w_illegal = 1'b1;
    endcase
    w_zero = (bus.opcode == OP_BEQ) ? (bus.in1 == bus.in2) : (w_result == '0);
  end

  assign w_mulLoad = (r_state == S_IDLE) && bus.start && w_isMul;
  assign w_mulStep = (r_state == S_MUL);

  seq_multiplier #(.WIDTH(WIDTH)) u_mult (
    .clk       (clk),
    .rst       (rst),
    .i_load    (w_mulLoad),
    .i_step    (w_mulStep),
    .i_mcand   (bus.in1),
    .i_mplier  (bus.in2),
    .o_last    (w_mulLast),
    .o_product (w_product)
  );

  // Control FSM and output registers; done is the only pulsed output
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_result   <= '0;
      r_resultHi <= '0;
      r_rw       <= 1'b0;
      r_zero     <= 1'b0;
      r_overflow <= 1'b0;
      r_illegal  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            if (w_isMul) begin
              r_state <= S_MUL;
              r_busy  <= 1'b1;
            end else begin
              r_result   <= w_result;
              r_resultHi <= '0;
              r_rw       <= w_rw;
              r_zero     <= w_zero;
              r_overflow <= w_overflow;
              r_illegal  <= w_illegal;
              r_done     <= 1'b1;
            end
          end
        end
        S_MUL: begin
          if (w_mulLast) begin
            r_state    <= S_IDLE;
            r_busy     <= 1'b0;
            r_done     <= 1'b1;
            r_result   <= w_product[WIDTH-1:0];
            r_resultHi <= w_product[2*WIDTH-1:WIDTH];
            r_rw       <= 1'b1;
            r_zero     <= (w_product[WIDTH-1:0] == '0);
            r_overflow <= 1'b0;
            r_illegal  <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.result    = r_result;
  assign bus.result_hi = r_resultHi;
  assign bus.rw        = r_rw;
  assign bus.zero      = r_zero;
  assign bus.overflow  = r_overflow;
  assign bus.illegal   = r_illegal;

endmodule

// File: doc/multicycle_alu.md
Name: multicycle_alu

Overview:
Parametrised, registered ALU for the soft processor, and the next generation of the combinational ALU. It accepts one operation per start pulse and registers the result, the write-enable and the flags. It adds signed overflow detection, SLT, XOR, NOR and SRA, plus an iterative unsigned multiply (MULTU) that produces a hi/lo pair. It sits between the register-file read stage and the write-back stage, and the control unit stalls on busy.

Parameters:
WIDTH, 32, datapath width in bits (power of two, at least 8).
SHW, $clog2(WIDTH), shift-amount width (derived; not overridden).

Ports:
clk  input  1  single clock; all state updates on the rising edge.
rst  input  1  synchronous, active-high reset.
start  input  1  request; sampled only while busy=0.
opcode  input  6  MIPS primary opcode.
funct  input  6  MIPS function field (used when opcode=000000).
shamt  input  SHW  shift amount; applied to in2 (Rt).
in1  input  WIDTH  operand Rs.
in2  input  WIDTH  operand Rt / immediate.
busy  output  1  high while a multiply is in progress.
done  output  1  one-cycle pulse when the outputs become valid.
result  output  WIDTH  primary result (lo half for MULTU).
result_hi  output  WIDTH  hi half for MULTU; 0 for all other operations.
rw  output  1  register write enable (1=write, 0=no write).
zero  output  1  1 when in1==in2 for BEQ; otherwise 1 when result==0.
overflow  output  1  signed overflow for ADD/SUB; 0 otherwise.
illegal  output  1  1 when the opcode/funct pair is unsupported.

Behaviour:
- Reset (rst=1 at an edge): state=IDLE; busy, done, result, result_hi, rw, zero, overflow, illegal and the internal counter all go to 0. Reset overrides start and aborts any multiply in flight; the cycle after reset is IDLE, with nothing pending.
- States: IDLE and MUL.
- IDLE with start=1 and a single-cycle operation: the operation executes that cycle, outputs register on the edge, and done=1 on the next cycle (latency 1). The FSM stays in IDLE.
- Single-cycle operations and results:
  - ADD 100000: in1+in2, rw=1.
  - SUB 100010: in1-in2, rw=1.
  - AND 100100, OR 100101, XOR 100110, NOR 100111: bitwise, rw=1.
  - SLT 101010: signed in1<in2 gives 1, else 0; rw=1.
  - SLL 000000, SRL 000010: logical shift of in2 by shamt; rw=1.
  - SRA 000011: arithmetic shift of in2 by shamt, sign-filled; rw=1.
  - LW (opcode 100011): sum, rw=1.
  - SW (opcode 101011): sum, rw=0.
  - BEQ (opcode 000100): result=in1-in2, rw=0, zero=(in1==in2).
- Overflow:
  - ADD: set when the operands share a sign and the sum's sign differs.
  - SUB: set when the operand signs differ and the result sign differs from in1.
  - The result is written regardless; no trap.
- MULTU (funct 011001): in IDLE with start=1, latch the operands, clear the accumulator, set busy=1 on the next cycle and enter MUL.
  - Each MUL cycle performs one shift-add step; there are exactly WIDTH steps.
  - After the last step, return to IDLE with busy=0 and done=1 in the same cycle.
  - Total latency from the start edge to done is WIDTH+1 cycles.
  - {result_hi,result} holds the 2*WIDTH-bit product; rw=1.
- Unsupported opcode/funct: illegal=1, rw=0, result=0, done still pulses after 1 cycle.
- start while busy=1 is ignored and not queued.
- Back-to-back: start is accepted in the same cycle that done=1.
- Outputs hold their values until the next accepted operation or reset; only done is a pulse.
- zero for non-BEQ operations is derived from the registered result.

Decomposition:
- Shared package alu_pkg:
  - opcode constants: OP_RTYPE, OP_LW, OP_SW, OP_BEQ.
  - funct constants: F_ADD, F_SUB, F_AND, F_OR, F_XOR, F_NOR, F_SLT, F_SLL, F_SRL, F_SRA, F_MULTU.
  - the FSM state type.
- One sub-module, seq_multiplier(WIDTH): a shift-add core with load/step/count interface that owns the counter and the 2*WIDTH accumulator. The top level owns the FSM, the single-cycle datapath and the output registers.

Test Plan:
1. ADD in1=0x7FFFFFFF, in2=0x00000001, start for 1 cycle -> next cycle done=1, result=0x80000000, overflow=1, rw=1, zero=0.
2. MULTU in1=0xFFFFFFFF, in2=0x00000002 -> busy high for 32 cycles; done exactly 33 cycles after the start edge; result_hi=0x00000001, result=0xFFFFFFFE, rw=1.
3. BEQ in1=in2=0x00000005 -> zero=1, result=0, rw=0; then BEQ in1=5, in2=3 -> zero=0, result=2.
4. MULTU start, rst=1 at cycle 10, with an extra start pulse at cycle 5 -> the extra start is ignored; after reset busy=0, all outputs 0, no done pulse; a following SUB 10-3 returns 7 one cycle later.
5. Illegal funct 111111 with opcode 000000 -> done=1, illegal=1, rw=0, result=0. The next SLT with in1=0xFFFFFFFF, in2=0x1 -> result=1, illegal=0.
6. WIDTH=8 instance: SRA in2=0x80, shamt=3 -> result=0xF0. SRL in2=0x80, shamt=3 -> 0x10. Back-to-back start on the done cycle is accepted.
